lms_filter_mc: RTL and testbench
================================

// Module: lms_filter_mc
// PURPOSE
//  Multi-channel adaptive FIR (LMS family) for the adaptive-filtering chain: NCH independent N-tap filters
//  time-share one multiplier/accumulator. Per accepted sample: y=sum(w*u), e=d-y, then update w.
//  Adds channel multiplexing, sign-error / sign-sign / freeze modes, per-channel coefficient clear and saturation.
// PARAMETERS
//  N     17  taps per channel (>=2)
//  DW    16  data width of u, d, y, e, mu; signed Q1.(DW-1)
//  CW    16  coefficient width; signed Q1.(CW-1)
//  NCH   4   channel count (>=1); CHW = max(1,$clog2(NCH))
// PORTS
//  clk       in   1    rising-edge clock
//  rst       in   1    asynchronous, active-high reset
//  in_valid  in   1    u_in/d_in/in_ch valid
//  in_ready  out  1    block idle; sample accepted when in_valid & in_ready
//  in_ch     in   CHW  channel of input sample (values >=NCH: sample accepted, discarded, no output)
//  u_in      in   DW   reference input u
//  d_in      in   DW   desired input d
//  mode      in   2    00 LMS, 01 sign-error, 10 sign-sign, 11 freeze (filter only); sampled at accept
//  mu_in     in   DW   step size, unsigned Q0.(DW)... treated as signed Q1.(DW-1), must be >=0
//  mu_we     in   1    load mu_in into mu register (any state)
//  clr_coef  in   1    zero all coefficients of channel in_ch (honoured only in IDLE)
//  out_valid out  1    one-cycle pulse: y_out/e_out/out_ch valid
//  out_ch    out  CHW  channel of result
//  y_out     out  DW   filter output, saturated
//  e_out     out  DW   error d-y, saturated
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, y_out=e_out=0, out_ch=0, mu=0, all delay lines and coefficients =0.
//  Reset mid-operation aborts the sample; no out_valid, no partial coefficient write survives.
//  in_ready = (state==IDLE) & ~clr_coef (combinational). clr_coef in IDLE: zero w[in_ch][0..N-1] in one cycle.
//  FSM: IDLE -> SHIFT -> FILT(N cyc) -> ERR -> UPD(N cyc) -> IDLE; mode 11 goes ERR -> IDLE.
//  Timing (accept at cycle T): T+1 SHIFT: dl[c] shifts, dl[c][0]=u_in; mode, mu, d, c latched at T.
//   T+2..T+N+1 FILT: acc += w[c][k]*dl[c][k], k=0..N-1; acc width 2*max(DW,CW)+clog2(N).
//   T+N+2 ERR: y=sat_DW(acc>>>(CW-1)), e=sat_DW(d-y), both with DW+1-bit intermediate.
//   T+N+3: out_valid=1 with y_out,e_out,out_ch registered; UPD runs T+N+3..T+2N+2; in_ready=1 at T+2N+3.
//   Freeze: in_ready=1 at T+N+3. Total latency accept->out_valid = N+3 cycles in all modes.
//  Update: g(x)=x (identity) or sgn(x) as +max/-max/0 in Q1.(DW-1);
//   LMS: w+=(mu*e>>>(DW-1))*u_k>>>(DW-1); sign-error: e->g(e); sign-sign: e->g(e), u_k->g(u_k).
//   New w saturated to CW bits (no wrap); u_k is dl value used in FILT (post-shift).
//  mu_we: mu register updates next edge; sample in flight keeps mu captured at accept.
//  in_valid while busy: not accepted, upstream holds. Channels fully independent; others untouched.
//  Simultaneous clr_coef & in_valid in IDLE: clear wins, sample waits one cycle.
// STRUCTURE
//  Shared include lms_defs.vh: state encoding, mode codes (LMS/SE/SS/FRZ), sat() and sgn() functions.
//  One sub-module lms_mac: signed multiply + accumulate with clear and saturating rescale; used for FILT and UPD.
//  Storage: dl[NCH*N], w[NCH*N] register arrays, indexed c*N+k.
// TESTING
//  1 Reset: rst pulse mid-UPD -> out_valid stays 0, all w=0, in_ready=1 one cycle after release.
//  2 Latency: N=17, mode 00, u=0x0801, d=0xC000, mu=0x0DF3, w=0 -> out_valid at T+20, y=0, e=0xC000.
//  3 Convergence: d=u delayed 3 samples, mode 00, 2000 samples ch0 -> w[0][3]>0x7000, others |w|<0x0100, |e|<0x0080.
//  4 Channels: interleave ch0/ch1 with different plants -> each converges independently; clr_coef ch1 leaves ch0 w unchanged.
//  5 Modes: mode 11 with preloaded w -> w unchanged, in_ready back at T+N+3; mode 10 step magnitude = mu per tap.
//  6 Saturation: u=d=0x7FFF, mu=0x7FFF, 50 samples -> w, y_out, e_out clip at 0x7FFF/0x8000, never wrap.

Source files
------------

// File: rtl/lms_filter_mc_pkg.sv
// Shared definitions for the multi-channel LMS filter: state encoding,
// update-mode codes and the saturate / sign helpers used by the datapath.
package lms_filter_mc_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHIFT = 3'd1;
   localparam logic [2:0] ST_FILT  = 3'd2;
   localparam logic [2:0] ST_ERR   = 3'd3;
   localparam logic [2:0] ST_UPD   = 3'd4;

   localparam logic [1:0] MODE_LMS = 2'b00;
   localparam logic [1:0] MODE_SE  = 2'b01;
   localparam logic [1:0] MODE_SS  = 2'b10;
   localparam logic [1:0] MODE_FRZ = 2'b11;

   typedef logic signed [63:0] wide_t;

   // Clamp x to the signed range of a w-bit word
   function automatic wide_t sat(input wide_t x, input int unsigned w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // Sign of x as +max / -max / 0 of a w-bit word
   function automatic wide_t sgn(input wide_t x, input int unsigned w);
      wide_t hi;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      if (x > wide_t'(0)) return hi;
      if (x < wide_t'(0)) return -hi;
      return wide_t'(0);
   endfunction

endpackage

// File: rtl/lms_filter_mc_mac.sv
// Shared signed multiplier with accumulator. The combinational product serves
// the coefficient update; the accumulator plus saturating rescale forms y.
module lms_filter_mc_mac
   import lms_filter_mc_pkg::*;
#(
   parameter int unsigned AW   = 16,
   parameter int unsigned BW   = 16,
   parameter int unsigned ACCW = 37,
   parameter int unsigned SH   = 15,
   parameter int unsigned OW   = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clr,
   input  logic                     i_en,
   input  logic signed [AW-1:0]     i_a,
   input  logic signed [BW-1:0]     i_b,
   output logic signed [AW+BW-1:0]  o_prod_c,
   output logic signed [OW-1:0]     o_sat_c
);

   logic signed [ACCW-1:0] r_acc;

   assign o_prod_c = i_a * i_b;
   assign o_sat_c  = OW'(sat(wide_t'(r_acc) >>> SH, OW));

   // Accumulator: cleared before a filter pass, adds one product per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + ACCW'(o_prod_c);
      end
   end

endmodule

// File: rtl/lms_filter_mc.sv
// Multi-channel adaptive FIR (LMS / sign-error / sign-sign / freeze).
// NCH independent N-tap filters share one multiplier; one sample in flight.
module lms_filter_mc
   import lms_filter_mc_pkg::*;
#(
   parameter int unsigned N   = 17,
   parameter int unsigned DW  = 16,
   parameter int unsigned CW  = 16,
   parameter int unsigned NCH = 4,
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CHW-1:0]        in_ch,
   input  logic signed [DW-1:0]  u_in,
   input  logic signed [DW-1:0]  d_in,
   input  logic [1:0]            mode,
   input  logic signed [DW-1:0]  mu_in,
   input  logic                  mu_we,
   input  logic                  clr_coef,
   output logic                  out_valid,
   output logic [CHW-1:0]        out_ch,
   output logic signed [DW-1:0]  y_out,
   output logic signed [DW-1:0]  e_out
);

   localparam int unsigned MW    = (DW > CW) ? DW : CW;
   localparam int unsigned ACCW  = 2 * MW + $clog2(N);
   localparam int unsigned DEPTH = NCH * N;
   localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned KW    = $clog2(N);

   logic [2:0]              r_state, w_state_nxt;
   logic [KW-1:0]           r_k;
   logic [CHW-1:0]          r_ch, r_out_ch;
   logic [1:0]              r_mode;
   logic signed [DW-1:0]    r_mu, r_mu_s, r_d, r_u, r_step, r_y, r_e;
   logic                    r_out_valid;
   logic signed [DW-1:0]    r_dl [DEPTH];
   logic signed [CW-1:0]    r_w  [DEPTH];

   logic                    w_accept, w_ch_ok, w_mac_clr, w_mac_en;
   logic [IW-1:0]           w_idx;
   logic signed [CW-1:0]    w_w_cur, w_w_new;
   logic signed [DW-1:0]    w_dl_cur, w_u_g, w_y, w_e, w_e_g, w_step;
   logic signed [MW-1:0]    w_mac_a;
   logic signed [DW-1:0]    w_mac_b;
   logic signed [MW+DW-1:0] w_prod;
   logic signed [2*DW-1:0]  w_mu_e;

   assign in_ready = (r_state == ST_IDLE) & ~clr_coef;
   assign w_accept = in_valid & in_ready;
   assign w_ch_ok  = (32'(in_ch) < NCH);

   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;
   assign y_out     = r_y;
   assign e_out     = r_e;

   lms_filter_mc_mac #(
      .AW   (MW),
      .BW   (DW),
      .ACCW (ACCW),
      .SH   (CW - 1),
      .OW   (DW)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_mac_clr),
      .i_en     (w_mac_en),
      .i_a      (w_mac_a),
      .i_b      (w_mac_b),
      .o_prod_c (w_prod),
      .o_sat_c  (w_y)
   );

   // Next-state and MAC control
   always_comb begin
      w_state_nxt = r_state;
      w_mac_clr   = 1'b0;
      w_mac_en    = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_accept && w_ch_ok) w_state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            w_mac_clr   = 1'b1;
            w_state_nxt = ST_FILT;
         end
         ST_FILT: begin
            w_mac_en = 1'b1;
            if (r_k == KW'(N - 1)) w_state_nxt = ST_ERR;
         end
         ST_ERR:   w_state_nxt = (r_mode == MODE_FRZ) ? ST_IDLE : ST_UPD;
         ST_UPD:   if (r_k == KW'(N - 1)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: tap selection, error, step size and coefficient update value
   always_comb begin
      w_idx    = IW'(r_ch) * IW'(N) + IW'(r_k);
      w_w_cur  = r_w[w_idx];
      w_dl_cur = r_dl[w_idx];
      w_u_g    = (r_mode == MODE_SS) ? DW'(sgn(wide_t'(w_dl_cur), DW)) : w_dl_cur;
      w_mac_a  = (r_state == ST_UPD) ? MW'(r_step) : MW'(w_w_cur);
      w_mac_b  = (r_state == ST_UPD) ? w_u_g : w_dl_cur;
      w_e      = DW'(sat(wide_t'(r_d) - wide_t'(w_y), DW));
      w_e_g    = (r_mode == MODE_LMS) ? w_e : DW'(sgn(wide_t'(w_e), DW));
      w_mu_e   = r_mu_s * w_e_g;
      w_step   = DW'(sat(wide_t'(w_mu_e) >>> (DW - 1), DW));
      w_w_new  = CW'(sat(wide_t'(w_w_cur) + (wide_t'(w_prod) >>> (DW - 1)), CW));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Tap counter, restarted before each FILT and UPD pass
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k <= '0;
      end else if (r_state == ST_SHIFT || r_state == ST_ERR) begin
         r_k <= '0;
      end else if (r_state == ST_FILT || r_state == ST_UPD) begin
         r_k <= (r_k == KW'(N - 1)) ? '0 : r_k + KW'(1);
      end
   end

   // Step-size register and per-sample context captured at accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mu   <= '0;
         r_mu_s <= '0;
         r_ch   <= '0;
         r_mode <= MODE_LMS;
         r_d    <= '0;
         r_u    <= '0;
      end else begin
         if (mu_we) r_mu <= mu_in;
         if (w_accept && w_ch_ok) begin
            r_ch   <= in_ch;
            r_mode <= mode;
            r_mu_s <= r_mu;
            r_d    <= d_in;
            r_u    <= u_in;
         end
      end
   end

   // Result registers and update step, loaded on leaving ERR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_y         <= '0;
         r_e         <= '0;
         r_step      <= '0;
      end else begin
         r_out_valid <= (r_state == ST_ERR);
         if (r_state == ST_ERR) begin
            r_out_ch <= r_ch;
            r_y      <= w_y;
            r_e      <= w_e;
            r_step   <= w_step;
         end
      end
   end

   // Delay lines: active channel shifts in its new sample during SHIFT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_dl[i] <= '0;
      end else if (r_state == ST_SHIFT) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (CHW'(c) == r_ch) begin
               r_dl[IW'(c * N)] <= r_u;
               for (int unsigned j = 1; j < N; j++)
                  r_dl[IW'(c * N + j)] <= r_dl[IW'(c * N + j - 1)];
            end
         end
      end
   end

   // Coefficients: whole-channel clear in IDLE, one tap per UPD cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_w[i] <= '0;
      end else if (r_state == ST_IDLE && clr_coef && w_ch_ok) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (CHW'(c) == in_ch) begin
               for (int unsigned j = 0; j < N; j++) r_w[IW'(c * N + j)] <= '0;
            end
         end
      end else if (r_state == ST_UPD) begin
         r_w[w_idx] <= w_w_new;
      end
   end

endmodule

// File: tb/tb_lms_filter_mc.sv
// Scoreboard bench for lms_filter_mc: a bit-exact reference model predicts
// y/e/channel and latency for every accepted sample.
module tb_lms_filter_mc;

   localparam int N   = 17;
   localparam int NCH = 4;
   localparam int CHW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, mu_we, clr_coef, out_valid;
   logic [CHW-1:0]    in_ch, out_ch;
   logic signed [15:0] u_in, d_in, mu_in, y_out, e_out;
   logic [1:0]        mode;

   typedef struct {
      int     ch;
      longint y;
      longint e;
      longint cyc;
   } exp_t;

   exp_t   sb[$];
   longint mw  [NCH][N];
   longint mdl [NCH][N];
   longint mmu;
   longint cyc = 0;
   longint last_drive;
   longint last_y [NCH];
   longint last_e [NCH];
   longint sum_abs [NCH];
   int     cnt_abs [NCH];
   bit     meas_en;
   int     n_chk = 0;
   int     n_err = 0;

   lms_filter_mc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch     (in_ch),
      .u_in      (u_in),
      .d_in      (d_in),
      .mode      (mode),
      .mu_in     (mu_in),
      .mu_we     (mu_we),
      .clr_coef  (clr_coef),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .y_out     (y_out),
      .e_out     (e_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   function automatic longint sat16(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic longint sgn16(input longint x);
      if (x > 0) return 32767;
      if (x < 0) return -32767;
      return 0;
   endfunction

   function automatic longint s16(input longint v);
      logic signed [15:0] t;
      t = 16'(v);
      return longint'(t);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < N; k++) begin
            mw[c][k]  = 0;
            mdl[c][k] = 0;
         end
      mmu = 0;
   endtask

   task automatic model_sample(input int ch, input longint u, input longint d,
                               input logic [1:0] md, input longint c0);
      longint acc, y, e, ge, step, uk;
      exp_t   x;
      for (int k = N - 1; k > 0; k--) mdl[ch][k] = mdl[ch][k-1];
      mdl[ch][0] = u;
      acc = 0;
      for (int k = 0; k < N; k++) acc += mw[ch][k] * mdl[ch][k];
      y = sat16(acc >>> 15);
      e = sat16(d - y);
      if (md != 2'b11) begin
         ge   = (md == 2'b00) ? e : sgn16(e);
         step = sat16((mmu * ge) >>> 15);
         for (int k = 0; k < N; k++) begin
            uk = (md == 2'b10) ? sgn16(mdl[ch][k]) : mdl[ch][k];
            mw[ch][k] = sat16(mw[ch][k] + ((step * uk) >>> 15));
         end
      end
      x.ch = ch; x.y = y; x.e = e; x.cyc = c0;
      sb.push_back(x);
   endtask

   task automatic set_mu(input longint v);
      @(negedge clk);
      mu_we = 1'b1;
      mu_in = 16'(v);
      @(negedge clk);
      mu_we = 1'b0;
      mmu   = s16(v);
   endtask

   task automatic wait_ready(output longint t);
      int g = 0;
      while (in_ready !== 1'b1 && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (in_ready !== 1'b1) check("ready_timeout", 0, 1);
      t = cyc;
   endtask

   task automatic send(input int ch, input longint u, input longint d, input logic [1:0] md);
      int g = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (in_ready !== 1'b1) begin
         check("send_timeout", 0, 1);
         return;
      end
      in_valid = 1'b1;
      in_ch    = CHW'(ch);
      u_in     = 16'(u);
      d_in     = 16'(d);
      mode     = md;
      model_sample(ch, s16(u), s16(d), md, cyc);
      last_drive = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("sb_drain", sb.size(), 0);
   endtask

   // Scoreboard: pop and compare each result pulse
   always @(negedge clk) begin
      exp_t x;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            x = sb.pop_front();
            check("out_ch", out_ch, x.ch);
            check("y_out", y_out, x.y);
            check("e_out", e_out, x.e);
            check("latency", cyc - x.cyc, N + 3);
            last_y[x.ch] = y_out;
            last_e[x.ch] = e_out;
            if (meas_en) begin
               sum_abs[x.ch] += (e_out < 0) ? -longint'(e_out) : longint'(e_out);
               cnt_abs[x.ch]++;
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint t, u, d, h0[4], h1[2];
      rst = 1'b1; in_valid = 1'b0; in_ch = '0; u_in = '0; d_in = '0;
      mode = 2'b00; mu_in = '0; mu_we = 1'b0; clr_coef = 1'b0; meas_en = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         sum_abs[c] = 0; cnt_abs[c] = 0; last_y[c] = 0; last_e[c] = 0;
      end
      for (int i = 0; i < 4; i++) h0[i] = 0;
      for (int i = 0; i < 2; i++) h1[i] = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_y_out", y_out, 0);
      check("rst_e_out", e_out, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      // first-sample latency and known answer
      set_mu(16'h0DF3);
      send(0, 16'h0801, 16'hC000, 2'b00);
      wait_ready(t);
      check("lms_ready_cycles", t - last_drive, 2 * N + 3);
      drain();
      check("first_y", last_y[0], 0);
      check("first_e", last_e[0], -16384);

      // ch0 converges to a 3-sample delay
      for (int i = 0; i < 600; i++) begin
         u = s16($urandom_range(0, 65535));
         h0[3] = h0[2]; h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = u;
         meas_en = (i >= 400);
         send(0, u, h0[3], 2'b00);
      end
      drain();
      meas_en = 1'b0;
      check("conv_ch0_mean_e_small", (cnt_abs[0] > 0 && sum_abs[0] / cnt_abs[0] < 128) ? 1 : 0, 1);

      // interleaved channels with different plants
      for (int c = 0; c < NCH; c++) begin sum_abs[c] = 0; cnt_abs[c] = 0; end
      for (int i = 0; i < 300; i++) begin
         meas_en = (i >= 200);
         u = s16($urandom_range(0, 65535));
         h0[3] = h0[2]; h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = u;
         send(0, u, h0[3], 2'b00);
         u = s16($urandom_range(0, 65535));
         h1[1] = h1[0]; h1[0] = u;
         send(1, u, h1[1] >>> 1, 2'b00);
      end
      drain();
      meas_en = 1'b0;
      check("conv_ch0_il_mean_e_small", (cnt_abs[0] > 0 && sum_abs[0] / cnt_abs[0] < 128) ? 1 : 0, 1);
      check("conv_ch1_il_mean_e_small", (cnt_abs[1] > 0 && sum_abs[1] / cnt_abs[1] < 128) ? 1 : 0, 1);

      // clear of ch1 together with a ch1 sample: clear first, sample a cycle later
      wait_ready(t);
      clr_coef = 1'b1; in_ch = 2'd1; in_valid = 1'b1;
      u_in = 16'h2000; d_in = 16'h1000; mode = 2'b00;
      #1;
      check("clr_blocks_ready", in_ready, 0);
      @(negedge clk);
      clr_coef = 1'b0;
      for (int k = 0; k < N; k++) mw[1][k] = 0;
      model_sample(1, 16'sh2000, 16'sh1000, 2'b00, cyc);
      last_drive = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      wait_ready(t);
      check("clr_sample_ready_cycles", t - last_drive, 2 * N + 3);
      for (int i = 0; i < 3; i++) send(0, s16($urandom_range(0, 65535)), 0, 2'b00);

      // freeze returns early and leaves w alone
      send(0, 16'h1234, 16'h4000, 2'b11);
      wait_ready(t);
      check("frz_ready_cycles", t - last_drive, N + 3);
      send(0, 16'h5678, 16'h0100, 2'b11);
      send(0, 16'hA000, 16'h0100, 2'b00);
      // mu change while a sample is in flight
      send(1, 16'h3000, 16'h7000, 2'b01);
      set_mu(16'h2000);
      send(1, 16'hC000, 16'h1000, 2'b01);
      send(1, 16'h4000, 16'h9000, 2'b10);
      // sign-sign step on a fresh channel
      set_mu(16'h0100);
      send(2, 16'h4000, 16'h4000, 2'b10);
      send(2, 16'h4000, 16'h0000, 2'b11);
      drain();
      check("ss_step_y", last_y[2], 127);
      check("ss_step_e", last_e[2], -127);

      // saturation on ch3
      set_mu(16'h7FFF);
      for (int i = 0; i < 50; i++)
         send(3, 16'h7FFF, (i < 25) ? 16'h7FFF : 16'h8000, 2'b00);
      drain();

      // reset in the middle of UPD
      send(3, 16'h7FFF, 16'h8000, 2'b00);
      repeat (N + 6) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      repeat (2) @(negedge clk);
      check("midrst_y_out", y_out, 0);
      check("midrst_e_out", e_out, 0);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1);
      send(3, 16'h1234, 16'h0100, 2'b11);
      send(3, 16'h7000, 16'h0100, 2'b11);
      send(0, 16'h6000, 16'h2000, 2'b00);
      send(0, 16'h6000, 16'h2000, 2'b00);
      drain();
      check("post_rst_y3", last_y[3], 0);
      check("post_rst_y0", last_y[0], 0);
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
